// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the execute-stage condition-code logic.
// Contents:
//   WIDTH_DEF             default datapath width
//   IC_OPQ, IC_JXX, IC_CMOV  icode values relevant to condition codes
//   alu_fun_t             OPq function codes
//   cond_t                jXX / cmovXX condition codes
package y86_pkg;

    localparam int WIDTH_DEF = 64;

    localparam logic [3:0] IC_OPQ  = 4'h6;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CMOV = 4'h2;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fun_t;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_t;

endpackage

// File: rtl/cond_eval.sv
// Condition evaluator for jXX / cmovXX.
// Ports:
//   ifun  in   condition code
//   zf, sf, of  in  registered flags
//   cnd   out  condition result (codes 7..15 evaluate to 0)
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    // Signed less-than after a compare: sign is only trustworthy when no overflow.
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_flag_unit.sv
// Execute-stage condition-code unit. Derives ZF/SF/OF/CF from the ALU
// result, registers them on valid OPq instructions, and evaluates Cnd for
// jXX/cmovXX from the flags as they stood before the current instruction.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   icode, ifun          current instruction
//   alu_a, alu_b         ALU operands (valA, valB)
//   alu_res, alu_cout    ALU result and carry/borrow-out
//   stat_ok              instruction status is AOK
//   cc_hold              stall: freeze CC this cycle
//   zf, sf, of, cf       registered flags (cf is diagnostic only)
//   cnd                  condition result, combinational
module cc_flag_unit
    import y86_pkg::*;
#(
    parameter int         WIDTH      = WIDTH_DEF,
    parameter logic [3:0] ICODE_OPQ  = IC_OPQ,
    parameter logic [3:0] ICODE_JXX  = IC_JXX,
    parameter logic [3:0] ICODE_CMOV = IC_CMOV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    input  logic             stat_ok,
    input  logic             cc_hold,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cf,
    output logic             cnd
);

    logic n_zf;
    logic n_sf;
    logic n_of;
    logic n_cf;
    logic set_cc;
    logic cnd_raw;
    logic a_msb;
    logic b_msb;
    logic t_msb;

    // Only the sign bits of the operands matter here; the rest feed the ALU.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};

    assign a_msb = alu_a[WIDTH-1];
    assign b_msb = alu_b[WIDTH-1];
    assign t_msb = alu_res[WIDTH-1];

    always_comb begin
        n_zf = (alu_res == '0);
        n_sf = t_msb;
        n_cf = alu_cout;
        n_of = 1'b0;
        case (ifun)
            ALU_ADD: n_of = (a_msb == b_msb) & (t_msb != a_msb);
            // Result is b - a, so overflow is judged against b's sign.
            ALU_SUB: n_of = (a_msb != b_msb) & (t_msb != b_msb);
            ALU_AND,
            ALU_XOR: n_cf = 1'b0;
            default: n_of = 1'b0;
        endcase
    end

    assign set_cc = (icode == ICODE_OPQ) & stat_ok & ~cc_hold & (ifun <= 4'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
            cf <= 1'b0;
        end else if (set_cc) begin
            zf <= n_zf;
            sf <= n_sf;
            of <= n_of;
            cf <= n_cf;
        end
    end

    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (zf),
        .sf   (sf),
        .of   (of),
        .cnd  (cnd_raw)
    );

    assign cnd = ((icode == ICODE_JXX) || (icode == ICODE_CMOV)) ? cnd_raw : 1'b0;

endmodule

// File: doc/cc_flag_unit.md
Name: cc_flag_unit

Overview:
- Execute-stage condition-code block for the SEQ Y86-64 core; sits directly downstream of the ALU (adder/subtractor/and/xor) and consumes its 64-bit result and carry-out.
- Computes ZF/SF/OF (plus a diagnostic CF) from the ALU result and operands, registers them on OPq instructions, and evaluates Cnd for jXX/cmovXX from the registered flags.
- Cnd is consumed by PC-update and write-back.

Parameters:
- WIDTH, 64, datapath width of ALU operands and result.
- ICODE_OPQ, 4'h6, icode that updates CC.
- ICODE_JXX, 4'h7, icode of conditional jumps.
- ICODE_CMOV, 4'h2, icode of rrmovq/cmovXX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- icode  input  4  current instruction icode.
- ifun  input  4  current instruction ifun (ALU op for OPq, condition for jXX/cmov).
- alu_a  input  WIDTH  aluA operand (valA for OPq).
- alu_b  input  WIDTH  aluB operand (valB for OPq).
- alu_res  input  WIDTH  ALU result valE (Sum from adder/subtractor, or logic result).
- alu_cout  input  1  ALU carry/borrow-out (carry_overflow).
- stat_ok  input  1  1 = instruction status AOK; 0 = exception/halt in flight.
- cc_hold  input  1  1 = freeze CC this cycle (stall).
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.
- cf  output  1  registered carry flag (diagnostic only, not used by Cnd).
- cnd  output  1  condition result for current instruction (combinational from registered flags).

Behaviour:
- Reset (rst_n=0 at posedge): zf=1, sf=0, of=0, cf=0; reset dominates all other inputs, including mid-instruction.
- Next-flag computation (combinational), with a=alu_a, b=alu_b, t=alu_res:
  - n_zf = (t==0); n_sf = t[WIDTH-1]; n_cf = alu_cout.
  - ifun 0 (addq): n_of = (a[msb]==b[msb]) & (t[msb]!=a[msb]).
  - ifun 1 (subq, t=b-a): n_of = (a[msb]!=b[msb]) & (t[msb]!=b[msb]).
  - ifun 2/3 (andq/xorq): n_of=0, n_cf=0.
  - ifun 4..15: n_of=0.
- Update condition: set_cc = (icode==ICODE_OPQ) & stat_ok & ~cc_hold & (ifun<=3).
  - When set_cc=1, all four flags load at posedge with 1-cycle latency.
  - Otherwise all flags hold.
  - An invalid OPq ifun (>3) never updates CC.
- cnd (no added latency; uses flags as registered before this instruction's own update), with S=sf^of:
  - ifun 0 always 1; 1 le S|zf; 2 l S; 3 e zf; 4 ne ~zf; 5 ge ~S; 6 g ~S&~zf; 7..15 0.
  - cnd is driven as above only when icode is ICODE_JXX or ICODE_CMOV; for all other icodes cnd=0.
- Back-to-back OPq: each cycle's update overwrites the previous one; a jXX in the cycle after an OPq sees the new flags.
- Exception: stat_ok=0 blocks the update even for a valid OPq, so CC is architecturally unchanged.
- cc_hold=1 with set_cc otherwise true: flags are unchanged and cnd is still evaluated normally.

Decomposition:
- Shared package y86_pkg: icode constants (OPQ, JXX, CMOV), ALU fun codes (ADD=0, SUB=1, AND=2, XOR=3), condition codes (ALWAYS..G = 0..6), WIDTH default.
- One sub-module cond_eval (pure combinational: ifun, zf, sf, of -> cnd).
- Flag computation and the CC register stay in cc_flag_unit.

Test Plan:
- Reset: hold rst_n=0 two cycles with icode=6, ifun=0 -> zf=1, sf=0, of=0, cf=0; next cycle icode=7, ifun=3 -> cnd=1.
- subq zero: a=5, b=5, t=0, cout=1, icode=6, ifun=1 -> after edge zf=1, sf=0, of=0, cf=1; then jXX ifun=3 (je) -> cnd=1, ifun=4 (jne) -> cnd=0.
- subq overflow: a=64'h1, b=64'h8000_0000_0000_0000, t=64'h7FFF_FFFF_FFFF_FFFF -> of=1, sf=0, zf=0; jl (ifun=2) -> cnd=1, jg -> cnd=0.
- addq overflow: a=b=64'h4000_0000_0000_0000, t=64'h8000_0000_0000_0000 -> of=1, sf=1; then xorq t=0 -> of=0, cf=0, zf=1.
- Blocked updates: prior state zf=1; OPq with t=7 and stat_ok=0 -> zf stays 1; repeat with cc_hold=1 -> zf stays 1; repeat with ifun=5 -> zf stays 1; repeat with stat_ok=1, cc_hold=0, ifun=0 -> zf=0.
- Reset mid-stream: flags sf=1, of=0 from prior OPq; assert rst_n=0 in the same cycle as a valid OPq with t=0 -> flags return to 1/0/0/0, not the OPq values; cmov ifun=6 (g) afterwards -> cnd=0; icode=3 with ifun=0 -> cnd=0.
